// File: rtl/pmmu_rmw.sv
// Pseudo MMU for the multi-cycle RV32I core: word memory with RV32I load/store
// handling, read-modify-write for sub-word stores and fault reporting.
//
// state | meaning
// IDLE  | accepting requests, mem_rdy_o=1
// READ  | waiting LATENCY cycles for the addressed word
// WRITE | single write edge of the (merged) word
// FAULT | rejected access, no memory side effects
// DONE  | one-cycle done_o pulse, fault_o valid
module pmmu_rmw #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  mem_rdy_o,
  output logic                  done_o,
  output logic                  fault_o
);
  localparam int AW = WORDS + 2;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("pmmu_rmw: only DATA_WIDTH=32 is supported");
  end
  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("pmmu_rmw: LATENCY must be in 1..7");
  end

  typedef enum logic [2:0] {IDLE, READ, WRITE, FAULT, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] mem [2**WORDS];
  logic [WORDS-1:0]      idx;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  legal;
  logic                  unused_addr_hi;

  // Upper address bits are deliberately dropped so accesses wrap.
  assign unused_addr_hi = ^addr_i[DATA_WIDTH-1:AW];
  assign idx   = addr_q[AW-1:2];
  assign rdata = mem[idx];

  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~addr_i[0];
      3'd2:    legal = (addr_i[1:0] == 2'b00);
      3'd4:    legal = ~we_i;
      3'd5:    legal = ~we_i & ~addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0] f3,
                                                     input logic [1:0] lane,
                                                     input logic [DATA_WIDTH-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    load_ext = {{24{b[7]}}, b};
      3'd1:    load_ext = {{16{h[15]}}, h};
      3'd4:    load_ext = {24'h0, b};
      3'd5:    load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [2:0] f3,
                                                        input logic [1:0] lane,
                                                        input logic [DATA_WIDTH-1:0] old,
                                                        input logic [DATA_WIDTH-1:0] wd);
    store_merge = old;
    case (f3[1:0])
      2'd0:    store_merge[{lane, 3'b000} +: 8] = wd[7:0];
      2'd1:    store_merge[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: store_merge = wd;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d   = we_i;
          f3_d   = funct3_i;
          addr_d = addr_i[AW-1:0];
          wdat_d = wd_i;
          if (!legal) begin
            state_d = FAULT;
          end else if (we_i && funct3_i == 3'd2) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            cnt_d   = 3'(LATENCY - 1);
          end
        end
      end
      READ: begin
        if (cnt_q == 3'd0) begin
          if (we_q) begin
            wdat_d  = store_merge(f3_q, addr_q[1:0], rdata, wdat_q);
            state_d = WRITE;
          end else begin
            rd_d    = load_ext(f3_q, addr_q[1:0], rdata);
            fault_d = 1'b0;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      WRITE: begin
        fault_d = 1'b0;
        state_d = DONE;
      end
      FAULT: begin
        fault_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == WRITE) mem[idx] <= wdat_q;
  end

  assign rd_o      = rd_q;
  assign mem_rdy_o = (state_q == IDLE);
  assign done_o    = (state_q == DONE);
  assign fault_o   = fault_q;
endmodule

// File: tb/tb_pmmu_rmw.sv
// Directed bench for pmmu_rmw: one instance at LATENCY=1 (sel=0) and one at
// LATENCY=3 (sel=1), driven from a table of hand-computed vectors.
module tb_pmmu_rmw;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req1 = 1'b0, req3 = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'd0;
  logic [31:0] addr = '0, wd = '0;
  logic [31:0] rd1, rd3;
  logic        rdy1, rdy3, done1, done3, flt1, flt3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pmmu_rmw #(.WORDS(10), .DATA_WIDTH(32), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wd_i(wd), .rd_o(rd1), .mem_rdy_o(rdy1), .done_o(done1),
    .fault_o(flt1));

  pmmu_rmw #(.WORDS(10), .DATA_WIDTH(32), .LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wd_i(wd), .rd_o(rd3), .mem_rdy_o(rdy3), .done_o(done3),
    .fault_o(flt3));

  typedef struct {
    logic        sel;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic        flt;
    logic        chk_rd;
    logic [31:0] rd;
    logic        hold;
  } vec_t;

  vec_t vecs[48];
  int   nv = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic sel, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input int lat,
                     input logic flt, input logic chk_rd, input logic [31:0] r,
                     input logic hold);
    vecs[nv] = '{sel, w, f, a, d, lat, flt, chk_rd, r, hold};
    nv++;
  endtask

  task automatic run(input vec_t v);
    int cyc;
    bit seen;
    @(negedge clk);
    chk("rdy_before", v.sel ? rdy3 : rdy1, 1'b1);
    we = v.we; f3 = v.f3; addr = v.addr; wd = v.wd;
    if (v.sel) req3 = 1'b1; else req1 = 1'b1;
    @(posedge clk); #1;
    if (!v.hold) begin req1 = 1'b0; req3 = 1'b0; end
    chk("rdy_busy", v.sel ? rdy3 : rdy1, 1'b0);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (v.sel ? done3 : done1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    req1 = 1'b0; req3 = 1'b0;
    chk("latency", 32'(cyc), 32'(v.lat));
    chk("fault", v.sel ? flt3 : flt1, v.flt);
    if (v.chk_rd) chk("rd", v.sel ? rd3 : rd1, v.rd);
    @(posedge clk); #1;
    chk("rdy_after", v.sel ? rdy3 : rdy1, 1'b1);
    chk("done_clear", v.sel ? done3 : done1, 1'b0);
    if (v.hold) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk("no_second_access", v.sel ? done3 : done1, 1'b0);
      end
    end
  endtask

  initial begin
    vec_t v;
    // sel we f3 addr wd lat flt chk_rd rd hold
    add(0, 1, 2, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0);
    add(0, 0, 2, 32'h10, 0, 2, 0, 1, 32'hDEADBEEF, 0);
    add(0, 0, 2, 32'h1010, 0, 2, 0, 1, 32'hDEADBEEF, 0);
    add(0, 1, 2, 32'h20, 32'h0, 2, 0, 1, 32'hDEADBEEF, 0);
    add(0, 1, 0, 32'h20, 32'h11, 3, 0, 0, 0, 0);
    add(0, 1, 0, 32'h21, 32'h22, 3, 0, 0, 0, 0);
    add(0, 1, 0, 32'h22, 32'h33, 3, 0, 0, 0, 0);
    add(0, 1, 0, 32'h23, 32'hFFFFFF44, 3, 0, 0, 0, 0);
    add(0, 0, 2, 32'h20, 0, 2, 0, 1, 32'h44332211, 0);
    add(0, 1, 2, 32'h30, 32'h80FF7F01, 2, 0, 0, 0, 0);
    add(0, 0, 0, 32'h31, 0, 2, 0, 1, 32'h0000007F, 0);
    add(0, 0, 0, 32'h32, 0, 2, 0, 1, 32'hFFFFFFFF, 0);
    add(0, 0, 4, 32'h33, 0, 2, 0, 1, 32'h00000080, 0);
    add(0, 0, 1, 32'h32, 0, 2, 0, 1, 32'hFFFF80FF, 0);
    add(0, 0, 5, 32'h32, 0, 2, 0, 1, 32'h000080FF, 0);
    add(0, 1, 2, 32'h40, 32'hCAFEF00D, 2, 0, 0, 0, 0);
    add(0, 0, 2, 32'h40, 0, 2, 0, 1, 32'hCAFEF00D, 0);
    add(0, 0, 1, 32'h41, 0, 2, 1, 1, 32'hCAFEF00D, 0);
    add(0, 1, 2, 32'h42, 32'h12345678, 2, 1, 1, 32'hCAFEF00D, 0);
    add(0, 0, 3, 32'h40, 0, 2, 1, 1, 32'hCAFEF00D, 0);
    add(0, 1, 4, 32'h40, 32'h0, 2, 1, 1, 32'hCAFEF00D, 0);
    add(0, 1, 1, 32'h43, 32'h0, 2, 1, 1, 32'hCAFEF00D, 0);
    add(0, 0, 2, 32'h40, 0, 2, 0, 1, 32'hCAFEF00D, 0);
    add(1, 1, 2, 32'h50, 32'h12345678, 2, 0, 0, 0, 0);
    add(1, 0, 2, 32'h50, 0, 4, 0, 1, 32'h12345678, 0);
    add(1, 1, 1, 32'h52, 32'h0000ABCD, 5, 0, 0, 0, 1);
    add(1, 0, 2, 32'h50, 0, 4, 0, 1, 32'hABCD5678, 0);
    add(1, 0, 0, 32'h53, 0, 4, 0, 1, 32'hFFFFFFAB, 0);
    add(1, 1, 2, 32'h60, 32'hA5A5A5A5, 2, 0, 1, 32'hFFFFFFAB, 0);

    #2;
    chk("reset_rd", rd1, 32'h0);
    chk("reset_done", {31'h0, done1}, 32'h0);
    chk("reset_fault", {31'h0, flt1}, 32'h0);
    chk("reset_rdy", {31'h0, rdy3}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) run(vecs[i]);

    // Reset in the middle of an SB's READ phase on the LATENCY=3 instance.
    @(negedge clk);
    we = 1'b1; f3 = 3'd0; addr = 32'h61; wd = 32'hFF;
    req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rd", rd3, 32'h0);
    chk("midreset_done", {31'h0, done3}, 32'h0);
    chk("midreset_fault", {31'h0, flt3}, 32'h0);
    chk("midreset_rdy", {31'h0, rdy3}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b1, 1'b0, 3'd2, 32'h60, 32'h0, 4, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};
    run(v);
    v = '{1'b1, 1'b1, 3'd0, 32'h61, 32'h5A, 5, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0};
    run(v);
    v = '{1'b1, 1'b0, 3'd2, 32'h60, 32'h0, 4, 1'b0, 1'b1, 32'hA5A55AA5, 1'b0};
    run(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
